// File: rtl/alu_exec_unit_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_if
// Handshake bundle for the execute-stage ALU.
//   Request side : in_valid / in_ready, alu_ctrl, src_a, src_b, shamt
//   Response side: out_valid / out_ready, result, zero, overflow, illegal
// Modports:
//   master - upstream producer + downstream consumer (drives requests,
//            accepts results)
//   slave  - the ALU itself
// ---------------------------------------------------------------------------
interface alu_exec_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         alu_ctrl;
    logic [WIDTH-1:0]   src_a;
    logic [WIDTH-1:0]   src_b;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic               overflow;
    logic               illegal;

    modport master (
        output in_valid, alu_ctrl, src_a, src_b, shamt, out_ready,
        input  in_ready, out_valid, result, zero, overflow, illegal
    );

    modport slave (
        input  in_valid, alu_ctrl, src_a, src_b, shamt, out_ready,
        output in_ready, out_valid, result, zero, overflow, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage ALU for the multi-cycle MIPS datapath. Decodes the 4-bit
// ALUControl code; logic/arithmetic ops finish in one cycle, logical shifts
// iterate one bit per cycle. Result and flags are held until the consumer
// takes them, and stay on the outputs afterwards until the next completion.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - alu_exec_unit_if.slave (request + response handshakes)
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ADDU = 4'b0011;
    localparam logic [3:0] OP_SUBU = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_BEQ  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic               in_ready, out_valid, accept;
    logic [WIDTH-1:0]   work, work_sh;
    logic [SHAMT_W-1:0] cnt;
    logic               dir_right;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q, ovf_q, ill_q;

    // Single-cycle op evaluation
    logic [WIDTH-1:0] sum, diff, op_res;
    logic             op_ovf, op_ill, is_shift, msb_a, msb_b;

    assign sum      = bus.src_a + bus.src_b;
    assign diff     = bus.src_a - bus.src_b;
    assign msb_a    = bus.src_a[WIDTH-1];
    assign msb_b    = bus.src_b[WIDTH-1];
    assign is_shift = (bus.alu_ctrl == OP_SLL) || (bus.alu_ctrl == OP_SRL);

    always_comb begin
        op_res = '0;
        op_ovf = 1'b0;
        op_ill = 1'b0;
        case (bus.alu_ctrl)
            OP_ADD: begin
                op_res = sum;
                op_ovf = (msb_a == msb_b) && (sum[WIDTH-1] != msb_a);
            end
            OP_ADDU: op_res = sum;
            OP_SUB, OP_BEQ: begin
                op_res = diff;
                op_ovf = (msb_a != msb_b) && (diff[WIDTH-1] != msb_a);
            end
            OP_SUBU: op_res = diff;
            OP_SLT:  op_res = {{(WIDTH-1){1'b0}},
                               ($signed(bus.src_a) < $signed(bus.src_b))};
            OP_AND:  op_res = bus.src_a & bus.src_b;
            OP_OR:   op_res = bus.src_a | bus.src_b;
            OP_NOR:  op_res = ~(bus.src_a | bus.src_b);
            OP_XOR:  op_res = bus.src_a ^ bus.src_b;
            // A zero-distance shift completes immediately with B unchanged;
            // non-zero distances go through the SHIFT state instead.
            OP_SLL, OP_SRL: op_res = bus.src_b;
            default: op_ill = 1'b1;
        endcase
    end

    assign work_sh = dir_right ? (work >> 1) : (work << 1);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // FSM: next state and handshake outputs
    always_comb begin
        state_n   = state;
        in_ready  = (state == S_IDLE) && !reset;
        out_valid = (state == S_DONE);
        accept    = bus.in_valid && in_ready;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_shift && (bus.shamt != '0)) state_n = S_SHIFT;
                    else                               state_n = S_DONE;
                end
            end
            S_SHIFT: begin
                if (cnt == SHAMT_W'(1)) state_n = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iterative shifter, held result/flags
    always_ff @(posedge clk) begin
        if (reset) begin
            work      <= '0;
            cnt       <= '0;
            dir_right <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_shift && (bus.shamt != '0)) begin
                            work      <= bus.src_b;
                            cnt       <= bus.shamt;
                            dir_right <= (bus.alu_ctrl == OP_SRL);
                        end else begin
                            result_q <= op_res;
                            zero_q   <= (op_res == '0);
                            ovf_q    <= op_ovf;
                            ill_q    <= op_ill;
                        end
                    end
                end
                S_SHIFT: begin
                    work <= work_sh;
                    cnt  <= cnt - SHAMT_W'(1);
                    // Last step: publish the shifted value directly.
                    if (cnt == SHAMT_W'(1)) begin
                        result_q <= work_sh;
                        zero_q   <= (work_sh == '0);
                        ovf_q    <= 1'b0;
                        ill_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit: a directed vector table, hand-made
// multi-cycle sequences (reset in DONE, output back-pressure, reset mid-shift)
// and random ops compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_exec_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        il;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        il;
        int          lat;
    } exp_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: straight from the op definitions using wide signed math.
    function automatic exp_t model(input logic [3:0] ctrl, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t   e;
        longint s;
        e.res = 32'd0; e.o = 1'b0; e.il = 1'b0; e.lat = 1;
        case (ctrl)
            4'b0010, 4'b0011: begin
                s = longint'($signed(a)) + longint'($signed(b));
                e.res = s[31:0];
                if (ctrl == 4'b0010)
                    e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110, 4'b1111, 4'b0100: begin
                s = longint'($signed(a)) - longint'($signed(b));
                e.res = s[31:0];
                if (ctrl != 4'b0100)
                    e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b1100: e.res = ~(a | b);
            4'b0101: e.res = a ^ b;
            4'b1000: begin e.res = b << sh; e.lat = (sh == 0) ? 1 : int'(sh) + 1; end
            4'b1001: begin e.res = b >> sh; e.lat = (sh == 0) ? 1 : int'(sh) + 1; end
            default: e.il = 1'b1;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!bus.in_ready && n < 60) begin @(posedge clk); #1; n++; end
        chk({nm, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    // Full transaction: accept, measure latency, check outputs, hand off.
    task automatic run_op(input string nm, input logic [3:0] ctrl, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input exp_t e);
        int n;
        logic busy_hi;
        wait_ready(nm);
        bus.in_valid = 1'b1; bus.alu_ctrl = ctrl; bus.src_a = a; bus.src_b = b; bus.shamt = sh;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.src_a = $urandom; bus.src_b = $urandom; bus.alu_ctrl = 4'($urandom);
        n = 1; busy_hi = 1'b0;
        while (!bus.out_valid && n < 100) begin
            if (bus.in_ready) busy_hi = 1'b1;
            @(posedge clk); #1; n++;
        end
        chk({nm, "_lat"},  n, e.lat);
        chk({nm, "_busy"}, {31'd0, busy_hi}, 32'd0);
        chk({nm, "_res"},  bus.result, e.res);
        chk({nm, "_flags"}, {29'd0, bus.zero, bus.overflow, bus.illegal}, {29'd0, e.z, e.o, e.il});
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({nm, "_vld_drop"}, {31'd0, bus.out_valid}, 32'd0);
        chk({nm, "_retain"},   bus.result, e.res);
    endtask

    initial begin
        exp_t        e;
        logic [3:0]  codes[13];
        logic [3:0]  c;
        logic [31:0] ra, rb;
        logic [4:0]  rs;
        logic        seen;

        codes = '{4'b0010, 4'b0011, 4'b0110, 4'b1111, 4'b0100, 4'b0111, 4'b0000,
                  4'b0001, 4'b1100, 4'b0101, 4'b1000, 4'b1001, 4'b1010};

        //            ctrl     a             b             sh  res           z  o  il lat
        vecs[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 0,  32'h80000000, 0, 1, 0, 1};
        vecs[1]  = '{4'b0011, 32'h7FFFFFFF, 32'h00000001, 0,  32'h80000000, 0, 0, 0, 1};
        vecs[2]  = '{4'b1111, 32'h00001234, 32'h00001234, 0,  32'h00000000, 1, 0, 0, 1};
        vecs[3]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 0,  32'h00000001, 0, 0, 0, 1};
        vecs[4]  = '{4'b1100, 32'h00000000, 32'h00000000, 0,  32'hFFFFFFFF, 0, 0, 0, 1};
        vecs[5]  = '{4'b1000, 32'h00000000, 32'h00000001, 31, 32'h80000000, 0, 0, 0, 32};
        vecs[6]  = '{4'b1001, 32'h00000000, 32'h80000000, 0,  32'h80000000, 0, 0, 0, 1};
        vecs[7]  = '{4'b1010, 32'h12345678, 32'h9ABCDEF0, 0,  32'h00000000, 1, 0, 1, 1};
        vecs[8]  = '{4'b0110, 32'h80000000, 32'h00000001, 0,  32'h7FFFFFFF, 0, 1, 0, 1};
        vecs[9]  = '{4'b1001, 32'h00000000, 32'h80000000, 4,  32'h08000000, 0, 0, 0, 5};
        vecs[10] = '{4'b0101, 32'h0000F0F0, 32'h0000FF00, 0,  32'h00000FF0, 0, 0, 0, 1};
        vecs[11] = '{4'b0100, 32'h00000000, 32'h00000001, 0,  32'hFFFFFFFF, 0, 0, 0, 1};
        vecs[12] = '{4'b0000, 32'hFF00FF00, 32'h0F0F0F0F, 0,  32'h0F000F00, 0, 0, 0, 1};
        vecs[13] = '{4'b1000, 32'h00000000, 32'h00000003, 31, 32'h80000000, 0, 0, 0, 32};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.alu_ctrl = 4'd0;
        bus.src_a = '0; bus.src_b = '0; bus.shamt = '0;

        // Power-on reset
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_release_ready", {31'd0, bus.in_ready}, 32'd1);

        // Directed table
        foreach (vecs[i]) begin
            e.res = vecs[i].res; e.z = vecs[i].z; e.o = vecs[i].o;
            e.il = vecs[i].il;   e.lat = vecs[i].lat;
            run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].sh, e);
        end

        // Reset while holding a result in DONE
        wait_ready("rdone");
        bus.in_valid = 1'b1; bus.alu_ctrl = 4'b0001; bus.src_a = 32'h5; bus.src_b = 32'h0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("rdone_vld", {31'd0, bus.out_valid}, 32'd1);
        chk("rdone_res", bus.result, 32'h5);
        reset = 1'b1;
        #1;
        chk("rdone_rdy_in_rst", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rdone_vld0", {31'd0, bus.out_valid}, 32'd0);
        chk("rdone_res0", bus.result, 32'd0);
        chk("rdone_flags0", {29'd0, bus.zero, bus.overflow, bus.illegal}, 32'd0);
        chk("rdone_rdy1", {31'd0, bus.in_ready}, 32'd1);

        // Back-pressure in DONE with a pending request
        wait_ready("hold");
        bus.in_valid = 1'b1; bus.alu_ctrl = 4'b0010; bus.src_a = 32'd3; bus.src_b = 32'd4;
        @(posedge clk); #1;
        bus.alu_ctrl = 4'b0101; bus.src_a = 32'hFF; bus.src_b = 32'h0F;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold_vld%0d", k), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("hold_rdy%0d", k), {31'd0, bus.in_ready}, 32'd0);
            chk($sformatf("hold_res%0d", k), bus.result, 32'd7);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("hold_idle_vld", {31'd0, bus.out_valid}, 32'd0);
        chk("hold_idle_rdy", {31'd0, bus.in_ready}, 32'd1);
        chk("hold_idle_res", bus.result, 32'd7);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("hold_next_vld", {31'd0, bus.out_valid}, 32'd1);
        chk("hold_next_res", bus.result, 32'hF0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset during a shift
        wait_ready("rshift");
        bus.in_valid = 1'b1; bus.alu_ctrl = 4'b1000; bus.src_b = 32'h1; bus.shamt = 5'd10;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (bus.out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("rshift_no_vld", {31'd0, seen}, 32'd0);
        chk("rshift_res0", bus.result, 32'd0);
        chk("rshift_flags0", {29'd0, bus.zero, bus.overflow, bus.illegal}, 32'd0);

        // Random ops against the model
        for (int i = 0; i < 40; i++) begin
            c  = codes[$urandom_range(0, 12)];
            if (c == 4'b1010) c = (i % 2) ? 4'b1011 : 4'b1101;
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            if (i % 7 == 0) begin ra[31] = 1'b0; rb[31] = 1'b0; ra[30] = 1'b1; rb[30] = 1'b1; end
            rs = 5'($urandom_range(0, 31));
            e  = model(c, ra, rb, rs);
            run_op($sformatf("rnd%0d_op%h", i, c), c, ra, rb, rs, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALUControl code produced by the ALU decoder and computes the result.
- Sits between decode/register-read and writeback/branch logic in the multi-cycle MIPS datapath.
- Logic and arithmetic ops complete in 1 cycle. Logical shifts run iteratively, 1 bit per cycle.
- Valid/ready handshake on both input and output.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; max shift = 2^SHAMT_W - 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request present.
- in_ready  output  1  unit can accept a request this cycle.
- alu_ctrl  input  4  ALUControl operation code.
- src_a  input  WIDTH  operand A (rs).
- src_b  input  WIDTH  operand B (rt / immediate); also the operand that is shifted.
- shamt  input  SHAMT_W  shift amount for sll/srl.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow (add/sub codes only).
- illegal  output  1  unsupported alu_ctrl code received.

Behaviour:
- Encodings:
  - 0010 add (signed ovf)
  - 0011 addu (no ovf)
  - 0110 sub (signed ovf)
  - 1111 sub for beq (signed ovf)
  - 0100 subu (no ovf)
  - 0111 slt: signed A<B gives 1, else 0, zero-extended
  - 0000 and
  - 0001 or
  - 1100 nor
  - 0101 xor
  - 1000 sll: B << shamt
  - 1001 srl: B >> shamt, zero fill
- Any other code: result=0, zero=1, overflow=0, illegal=1. Latency is 1 cycle, same as simple ops.
- State machine:
  - IDLE
  - SHIFT: shift in progress.
  - DONE: output held.
- in_ready = (state==IDLE) && !reset.
- Accept occurs when in_valid && in_ready. Operands and code are captured on the accept edge and are ignored at all other times.
- IDLE, accept of a non-shift code: registered result/flags are loaded; next state DONE. out_valid rises the cycle after accept, so latency is 1.
- IDLE, accept of sll/srl:
  - shamt==0: result=B; next state DONE; latency 1.
  - shamt>0: working register gets B, counter gets shamt; next state SHIFT.
- SHIFT:
  - Each cycle shifts the working register 1 bit in the requested direction and decrements the counter.
  - When the counter reaches 1, the final shift is applied; next state DONE.
  - Latency = shamt+1 cycles from accept to out_valid.
- DONE:
  - out_valid=1.
  - result/zero/overflow/illegal stay stable until handshake.
  - out_ready=1 gives next state IDLE and out_valid deasserts the next cycle.
  - Result and flags retain their values after the handshake and change only on the next completion.
- Back-to-back throughput is 2 cycles per simple op: an input accept cannot coincide with a DONE handshake cycle.
- Arithmetic wraps modulo 2^WIDTH.
- Signed overflow:
  - add: operands have equal signs and the result sign differs.
  - sub: operand signs differ and the result sign differs from A.
  - Result is still written when overflow is set.
- zero is computed on the final result, including shift results. The beq path uses code 1111: zero=1 when A==B.
- overflow is 0 for addu, subu, slt, logic, shift, and illegal codes.
- Reset, including mid-SHIFT or in DONE:
  - State goes to IDLE and any in-flight op is discarded.
  - out_valid=0, result=0, zero=0, overflow=0, illegal=0, counter=0.
  - in_ready=0 while reset is asserted and 1 in the first cycle after deassertion.
- in_valid while not ready: the request is ignored, not queued. The upstream logic must hold it.

Test Plan:
- Reset in DONE with result 0x5, then deassert -> out_valid=0, result=0, all flags 0, in_ready=1 the next cycle.
- add A=0x7FFFFFFF, B=0x00000001 -> 1 cycle later out_valid=1, result=0x80000000, overflow=1, zero=0. Same operands with addu -> overflow=0.
- Code 1111 with A=B=0x1234 -> result=0, zero=1. slt with A=0xFFFFFFFF, B=0x1 -> result=1. nor with A=0, B=0 -> 0xFFFFFFFF.
- sll B=0x1, shamt=31 -> out_valid exactly 32 cycles after accept, result=0x80000000, in_ready=0 throughout. srl B=0x80000000, shamt=0 -> result=0x80000000 after 1 cycle.
- Hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> outputs stable, in_ready=0, no new accept. Then out_ready=1 -> IDLE and the held request is accepted the following cycle.
- Illegal code 1010 -> illegal=1, result=0, zero=1. Reset asserted at cycle 3 of sll shamt=10 -> out_valid never rises, all outputs 0.
